// File: rtl/lab1_imul_mul_share_arb_pkg.sv
// ============================================================================
// Module   : lab1_imul_arb_pkg
// Brief    : Shared types and widths for the two-port multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lab1_imul_arb_pkg;

  localparam int unsigned c_req_msg_w  = 64;
  localparam int unsigned c_resp_msg_w = 32;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_ISSUE = 2'd1,
    STATE_WAIT  = 2'd2,
    STATE_RESP  = 2'd3
  } arb_state_t;

  typedef logic [0:0] req_id_t;

endpackage

`default_nettype wire

// File: rtl/lab1_imul_mul_share_arb_if.sv
// ============================================================================
// Module   : lab1_imul_mul_share_arb_if
// Brief    : val/rdy request + response channel pair (64-bit req, 32-bit resp).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lab1_imul_mul_share_arb_if;
  import lab1_imul_arb_pkg::*;

  logic                    req_val;
  logic                    req_rdy;
  logic [c_req_msg_w-1:0]  req_msg;
  logic                    resp_val;
  logic                    resp_rdy;
  logic [c_resp_msg_w-1:0] resp_msg;

  // master issues requests and consumes responses
  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );

endinterface

`default_nettype wire

// File: rtl/lab1_imul_mul_share_arb_rrarb.sv
// ============================================================================
// Module   : lab1_imul_RoundRobinArb2
// Brief    : Combinational 2-way grant; tie goes to the port that was not last.
//            Holding i_last at 1 turns it into a port-0-first priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab1_imul_RoundRobinArb2
  import lab1_imul_arb_pkg::*;
(
  input  logic [1:0] i_val,
  input  req_id_t    i_last,
  output logic       o_gnt_val,
  output req_id_t    o_gnt_id
);

  always_comb begin
    o_gnt_val = i_val[0] | i_val[1];
    o_gnt_id  = 1'b0;
    if (i_val == 2'b11) begin
      o_gnt_id = ~i_last;
    end else if (i_val[1]) begin
      o_gnt_id = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lab1_imul_mul_share_arb.sv
// ============================================================================
// Module   : lab1_imul_mul_share_arb
// Brief    : Time-shares one val/rdy multiplier between two requesters, one
//            transaction in flight, product routed back to the issuer.
// Config   : LAB1_IMUL_ARB_RR_EN defined -> round-robin, else fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab1_imul_mul_share_arb
  import lab1_imul_arb_pkg::*;
#(
  parameter int P_NREQS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  lab1_imul_mul_share_arb_if.slave  in0,
  lab1_imul_mul_share_arb_if.slave  in1,
  lab1_imul_mul_share_arb_if.master mul
);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [c_req_msg_w-1:0]  r_req;
  logic [c_resp_msg_w-1:0] r_resp;
  req_id_t                 r_owner;
  req_id_t                 w_last;
  req_id_t                 w_gnt_id;
  logic [P_NREQS-1:0]      w_req_vals;
  logic                    w_gnt_val;
  logic                    w_req_hs;
  logic                    w_owner_resp_rdy;
  logic                    w_in0_req_rdy;
  logic                    w_in1_req_rdy;
  logic                    w_in0_resp_val;
  logic                    w_in1_resp_val;
  logic                    w_mul_req_val;
  logic                    w_mul_resp_rdy;

  assign w_req_vals = {in1.req_val, in0.req_val};

  lab1_imul_RoundRobinArb2 u_arb (
    .i_val     (w_req_vals),
    .i_last    (w_last),
    .o_gnt_val (w_gnt_val),
    .o_gnt_id  (w_gnt_id)
  );

  // The grant is combinational, so a granted port handshakes in the same cycle.
  assign w_req_hs         = (r_state == STATE_IDLE) && w_gnt_val && !reset;
  assign w_owner_resp_rdy = (r_owner == 1'b1) ? in1.resp_rdy : in0.resp_rdy;

`ifdef LAB1_IMUL_ARB_RR_EN
  req_id_t r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_req_hs) begin
      r_last <= w_gnt_id;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STATE_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= '0;
      r_owner <= '0;
    end else if (w_req_hs) begin
      r_req   <= (w_gnt_id == 1'b1) ? in1.req_msg : in0.req_msg;
      r_owner <= w_gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp <= '0;
    end else if (w_mul_resp_rdy && mul.resp_val) begin
      r_resp <= mul.resp_msg;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STATE_IDLE:  if (w_gnt_val)        w_state_nxt = STATE_ISSUE;
      STATE_ISSUE: if (mul.req_rdy)      w_state_nxt = STATE_WAIT;
      STATE_WAIT:  if (mul.resp_val)     w_state_nxt = STATE_RESP;
      STATE_RESP:  if (w_owner_resp_rdy) w_state_nxt = STATE_IDLE;
      default:                           w_state_nxt = STATE_IDLE;
    endcase
  end

  always_comb begin
    w_in0_req_rdy  = 1'b0;
    w_in1_req_rdy  = 1'b0;
    w_in0_resp_val = 1'b0;
    w_in1_resp_val = 1'b0;
    w_mul_req_val  = 1'b0;
    w_mul_resp_rdy = 1'b0;
    case (r_state)
      STATE_IDLE: begin
        w_in0_req_rdy = w_gnt_val && (w_gnt_id == 1'b0) && !reset;
        w_in1_req_rdy = w_gnt_val && (w_gnt_id == 1'b1) && !reset;
      end
      STATE_ISSUE: w_mul_req_val  = 1'b1;
      STATE_WAIT:  w_mul_resp_rdy = 1'b1;
      STATE_RESP: begin
        w_in0_resp_val = (r_owner == 1'b0);
        w_in1_resp_val = (r_owner == 1'b1);
      end
      default: ;
    endcase
  end

  assign in0.req_rdy  = w_in0_req_rdy;
  assign in1.req_rdy  = w_in1_req_rdy;
  assign in0.resp_val = w_in0_resp_val;
  assign in1.resp_val = w_in1_resp_val;
  assign in0.resp_msg = r_resp;
  assign in1.resp_msg = r_resp;
  assign mul.req_val  = w_mul_req_val;
  assign mul.req_msg  = r_req;
  assign mul.resp_rdy = w_mul_resp_rdy;

endmodule

`default_nettype wire

// File: tb/tb_lab1_imul_mul_share_arb.sv
// ============================================================================
// Module   : tb_lab1_imul_mul_share_arb
// Brief    : Self-checking bench with a transaction-level arbiter model and a
//            behavioural multiplier with variable latency and backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lab1_imul_mul_share_arb;
  import lab1_imul_arb_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lab1_imul_mul_share_arb_if in0_if ();
  lab1_imul_mul_share_arb_if in1_if ();
  lab1_imul_mul_share_arb_if mul_if ();

  lab1_imul_mul_share_arb #(.P_NREQS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .in0   (in0_if),
    .in1   (in1_if),
    .mul   (mul_if)
  );

  int total = 0;
  int bad   = 0;

  int mrdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
  int lat_cfg   = 1;   // 0 random 1..5, else fixed latency
  bit stray_en  = 1'b0;

  bit          m_busy, m_sent, m_got, m_owner, m_last;
  logic [63:0] m_msg;
  logic [31:0] m_prod;
  bit          grant_log[$];
  logic [32:0] resp_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_grant(input bit [1:0] v);
    if (v == 2'b11) begin
`ifdef LAB1_IMUL_ARB_RR_EN
      return !m_last;
`else
      return 1'b0;
`endif
    end
    return v[1];
  endfunction

  // Transaction-level model: lifecycle accept -> sent -> product back -> delivered
  initial begin
    bit [1:0] vals;
    bit       g;
    bit       exp_v;
    m_busy = 0; m_sent = 0; m_got = 0; m_owner = 0; m_last = 1;
    m_msg = '0; m_prod = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_busy = 0;
        m_last = 1;
        continue;
      end
      vals = {in1_if.req_val === 1'b1, in0_if.req_val === 1'b1};
      g    = model_grant(vals);
      chk("in0_req_rdy", in0_if.req_rdy, 64'(!m_busy && vals != 0 && g == 0));
      chk("in1_req_rdy", in1_if.req_rdy, 64'(!m_busy && vals != 0 && g == 1));
      exp_v = m_busy && !m_sent;
      chk("mul_req_val", mul_if.req_val, 64'(exp_v));
      if (exp_v) chk("mul_req_msg", mul_if.req_msg, m_msg);
      chk("mul_resp_rdy", mul_if.resp_rdy, 64'(m_busy && m_sent && !m_got));
      chk("in0_resp_val", in0_if.resp_val, 64'(m_busy && m_got && m_owner == 0));
      chk("in1_resp_val", in1_if.resp_val, 64'(m_busy && m_got && m_owner == 1));
      if (m_busy && m_got) begin
        chk("in0_resp_msg", 64'(in0_if.resp_msg), 64'(m_prod));
        chk("in1_resp_msg", 64'(in1_if.resp_msg), 64'(m_prod));
      end
      if (!m_busy) begin
        if (vals != 0) begin
          m_busy  = 1; m_sent = 0; m_got = 0;
          m_owner = g;
          m_msg   = g ? in1_if.req_msg : in0_if.req_msg;
          m_prod  = m_msg[63:32] * m_msg[31:0];
          m_last  = g;
          grant_log.push_back(g);
        end
      end else if (!m_sent) begin
        if (mul_if.req_rdy === 1'b1) m_sent = 1;
      end else if (!m_got) begin
        if (mul_if.resp_val === 1'b1) m_got = 1;
      end else if ((m_owner ? in1_if.resp_rdy : in0_if.resp_rdy) === 1'b1) begin
        m_busy = 0;
        resp_log.push_back({m_owner, m_prod});
      end
    end
  end

  // Behavioural multiplier: one outstanding op, optional stray response pulses
  initial begin
    bit hs_req, hs_resp, rs, pend, stray;
    int cnt;
    logic [31:0] prod;
    pend = 0; stray = 0; cnt = 0; prod = '0;
    mul_if.req_rdy = 1'b0; mul_if.resp_val = 1'b0; mul_if.resp_msg = '0;
    forever begin
      @(negedge clk);
      hs_req  = (mul_if.req_val === 1'b1) && (mul_if.req_rdy === 1'b1);
      hs_resp = (mul_if.resp_val === 1'b1) && (mul_if.resp_rdy === 1'b1);
      rs      = reset;
      if (hs_req) prod = mul_if.req_msg[63:32] * mul_if.req_msg[31:0];
      @(posedge clk); #1;
      if (rs) begin
        pend = 0; stray = 0; mul_if.resp_val = 1'b0;
      end else begin
        if (stray) begin stray = 0; mul_if.resp_val = 1'b0; end
        if (hs_resp) begin pend = 0; mul_if.resp_val = 1'b0; end
        if (hs_req) begin
          pend = 1;
          cnt  = ((lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 5))) - 1;
        end
        if (pend && !mul_if.resp_val) begin
          if (cnt == 0) begin mul_if.resp_val = 1'b1; mul_if.resp_msg = prod; end
          else cnt--;
        end else if (!pend && stray_en && $urandom_range(0, 1) == 0) begin
          stray = 1; mul_if.resp_val = 1'b1; mul_if.resp_msg = $urandom;
        end
      end
      mul_if.req_rdy = (mrdy_mode == 1) ? 1'b1 : (mrdy_mode == 2) ? 1'b0 :
                       1'($urandom_range(0, 3) != 0);
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input int p, input logic v, input logic [63:0] m);
    if (p == 0) begin in0_if.req_val = v; in0_if.req_msg = m; end
    else        begin in1_if.req_val = v; in1_if.req_msg = m; end
  endtask

  task automatic wait_accept(input int p);
    bit acc = 0;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      acc = ((p == 0) ? in0_if.req_rdy : in1_if.req_rdy) === 1'b1;
      @(posedge clk); #1;
    end
    if (p == 0) in0_if.req_val = 1'b0; else in1_if.req_val = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL accept_timeout port %0d: accepted 0 required 1", p);
    end
  endtask

  task automatic send(input int p, input logic [63:0] m);
    set_req(p, 1'b1, m);
    wait_accept(p);
  endtask

  task automatic wait_resp(input int p, input logic [31:0] exp, input string name);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (p == 0) seen = (in0_if.resp_val === 1'b1) && (in0_if.resp_rdy === 1'b1);
      else        seen = (in1_if.resp_val === 1'b1) && (in1_if.resp_rdy === 1'b1);
      if (seen) chk(name, 64'((p == 0) ? in0_if.resp_msg : in1_if.resp_msg), 64'(exp));
      @(posedge clk); #1;
    end
    if (!seen) chk({name, "_seen"}, 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(2);
    reset = 1'b0;
  endtask

  task automatic drv(input int p);
    repeat (25) begin
      cycle($urandom_range(0, 3));
      send(p, {$urandom, $urandom});
    end
  endtask

  initial begin
    bit rnd_on;
    bit seen;
    in0_if.req_val = 0; in0_if.req_msg = '0; in0_if.resp_rdy = 0;
    in1_if.req_val = 0; in1_if.req_msg = '0; in1_if.resp_rdy = 0;
    do_reset();

    // reset state and single transaction with fixed latency 4
    @(negedge clk);
    chk("rst_mul_req_val", mul_if.req_val, 0);
    chk("rst_mul_resp_rdy", mul_if.resp_rdy, 0);
    chk("rst_in0_resp_val", in0_if.resp_val, 0);
    chk("rst_in1_resp_val", in1_if.resp_val, 0);
    @(posedge clk); #1;
    lat_cfg = 4; mrdy_mode = 1;
    in0_if.resp_rdy = 1; in1_if.resp_rdy = 1;
    set_req(0, 1'b1, {32'd3, 32'd4});
    @(negedge clk);
    chk("t1_accept", in0_if.req_rdy, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, '0);
    @(negedge clk);
    chk("t1_mul_req_val", mul_if.req_val, 1);
    chk("t1_mul_req_msg", mul_if.req_msg, {32'd3, 32'd4});
    @(posedge clk); #1;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      chk("t1_resp_val_timing", in0_if.resp_val, 64'(k == 6));
      if (k == 6) chk("t1_resp_msg", 64'(in0_if.resp_msg), 64'h0000000C);
      @(posedge clk); #1;
    end

    // tie right after reset: in0 first
    do_reset();
    lat_cfg = 0; mrdy_mode = 0;
    resp_log.delete();
    fork
      send(0, {32'd2, 32'd3});
      send(1, {32'd5, 32'd7});
    join
    cycle(40);
    chk("t2_count", 64'(resp_log.size()), 64'd2);
    if (resp_log.size() >= 2) begin
      chk("t2_first", 64'(resp_log[0]), {31'd0, 1'b0, 32'd6});
      chk("t2_second", 64'(resp_log[1]), {31'd0, 1'b1, 32'd35});
    end

    // continuous contention
    grant_log.delete();
    fork
      repeat (6) send(0, {$urandom, $urandom});
      repeat (6) send(1, {$urandom, $urandom});
    join
    cycle(30);
    chk("t3_grant_count", 64'(grant_log.size() >= 6), 64'd1);
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
`ifdef LAB1_IMUL_ARB_RR_EN
        chk($sformatf("t3_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
`else
        chk($sformatf("t3_grant%0d", i), 64'(grant_log[i]), 64'd0);
`endif
      end
    end

    // response backpressure on in1 while in0 waits
    in1_if.resp_rdy = 0;
    send(1, {32'hFFFFFFFF, 32'h00000002});
    set_req(0, 1'b1, {32'd1, 32'd1});
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (in1_if.resp_val === 1'b1);
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("t4_resp_seen", 64'(seen), 64'd1);
    for (int k = 0; k < 10; k++) begin
      chk("t4_resp_val_hold", in1_if.resp_val, 1);
      chk("t4_resp_msg_hold", 64'(in1_if.resp_msg), 64'hFFFFFFFE);
      chk("t4_in0_blocked", in0_if.req_rdy, 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in1_if.resp_rdy = 1;
    wait_accept(0);
    wait_resp(0, 32'd1, "t4_in0_resp");

    // multiplier request backpressure with stray response pulses
    mrdy_mode = 2; stray_en = 1;
    send(0, {32'd9, 32'd9});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_mul_req_val", mul_if.req_val, 1);
      chk("t5_mul_req_msg", mul_if.req_msg, {32'd9, 32'd9});
      chk("t5_mul_resp_rdy", mul_if.resp_rdy, 0);
      @(posedge clk); #1;
    end
    mrdy_mode = 1; stray_en = 0;
    wait_resp(0, 32'd81, "t5_resp");

    // reset while waiting on the multiplier
    lat_cfg = 8;
    send(0, {32'd5, 32'd5});
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (mul_if.resp_rdy === 1'b1);
      @(posedge clk); #1;
    end
    chk("t6_in_wait", 64'(seen), 64'd1);
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_in0_resp_val", in0_if.resp_val, 0);
    chk("t6_in1_resp_val", in1_if.resp_val, 0);
    chk("t6_mul_req_val", mul_if.req_val, 0);
    chk("t6_mul_resp_rdy", mul_if.resp_rdy, 0);
    @(posedge clk); #1;
    lat_cfg = 0;
    send(1, {32'd6, 32'd7});
    wait_resp(1, 32'd42, "t6_resp");

    // randomized traffic on both ports
    mrdy_mode = 0; stray_en = 1;
    rnd_on = 1;
    fork
      begin
        fork
          drv(0);
          drv(1);
        join
        rnd_on = 0;
      end
      while (rnd_on) begin
        in0_if.resp_rdy = 1'($urandom_range(0, 2) != 0);
        in1_if.resp_rdy = 1'($urandom_range(0, 2) != 0);
        cycle(1);
      end
    join
    stray_en = 0;
    in0_if.resp_rdy = 1; in1_if.resp_rdy = 1;
    cycle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
